// File: rtl/icache_pkg.sv
// Shared types and default widths for the instruction-cache controller.
package icache_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefSize      = 128;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StMemReq,
    StFill,
    StFlush
  } state_e;

endpackage

// File: rtl/icache_sweep_counter.sv
// Index generator for the invalidation sweep: counts 0..SIZE-1 while enabled,
// returns to 0 when idle, on restart, or after the last index.
module icache_sweep_counter #(
  parameter int unsigned  SIZE = 128,
  localparam int unsigned CW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_en,
  input  logic          i_restart,
  output logic [CW-1:0] o_count,
  output logic          o_last
);

  logic [CW-1:0] count_q, count_d;

  assign o_last  = (count_q == CW'(SIZE - 1));
  assign o_count = count_q;

  always_comb begin
    count_d = '0;
    if (i_en && !i_restart && !o_last) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/icache_controller.sv
// Instruction-cache controller: zero-cycle hits, blocking miss fill from backing
// memory, and a full invalidation sweep at reset and on flush.
module icache_controller
  import icache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned SIZE       = DefSize
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rd,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_flush,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_set_addr,
  output logic                  o_set_wr,
  output logic                  o_set_cl,
  output logic [DATA_WIDTH-1:0] o_set_data,
  input  logic [DATA_WIDTH-1:0] i_set_data,
  input  logic                  i_set_hit,
  output logic                  o_mem_rd,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_ack
);

  localparam int unsigned CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    flush_pend_q, flush_pend_d;
  logic                    sweeping;
  logic [CW-1:0]           sweep_count;
  logic                    sweep_last;

  assign sweeping = (state_q == StInit) || (state_q == StFlush);

  icache_sweep_counter #(
    .SIZE (SIZE)
  ) u_sweep (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_en      (sweeping),
    .i_restart (i_flush),
    .o_count   (sweep_count),
    .o_last    (sweep_last)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    flush_pend_d = flush_pend_q;
    unique case (state_q)
      StInit, StFlush: begin
        // A flush mid-sweep restarts the counter and keeps us sweeping.
        if (!i_flush && sweep_last) state_d = StIdle;
      end
      StIdle: begin
        if (i_flush) begin
          state_d = StFlush;
        end else if (i_rd && !i_set_hit) begin
          addr_d  = i_addr;
          state_d = StMemReq;
        end
      end
      StMemReq: begin
        if (i_flush) flush_pend_d = 1'b1;
        if (i_mem_ack) begin
          data_d  = i_mem_data;
          state_d = StFill;
        end
      end
      StFill: begin
        if (flush_pend_q || i_flush) begin
          flush_pend_d = 1'b0;
          state_d      = StFlush;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    o_data     = '0;
    o_ready    = 1'b0;
    o_busy     = 1'b0;
    o_set_addr = '0;
    o_set_wr   = 1'b0;
    o_set_cl   = 1'b0;
    o_set_data = '0;
    o_mem_rd   = 1'b0;
    o_mem_addr = '0;
    unique case (state_q)
      StInit, StFlush: begin
        o_busy     = 1'b1;
        o_set_cl   = 1'b1;
        o_set_addr = ADDR_WIDTH'(sweep_count);
      end
      StIdle: begin
        if (i_rd && !i_flush) begin
          o_set_addr = i_addr;
          if (i_set_hit) begin
            o_ready = 1'b1;
            o_data  = i_set_data;
          end
        end
      end
      StMemReq: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = addr_q;
      end
      StFill: begin
        o_set_wr   = 1'b1;
        o_set_addr = addr_q;
        o_set_data = data_q;
        o_ready    = 1'b1;
        o_data     = data_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= StInit;
      addr_q       <= '0;
      data_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_icache_controller.sv
// Randomized bench: a behavioural cache-set and memory environment plus a
// transaction-level reference of cache contents and hit/miss timing.
module tb_icache_controller;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned SIZE = 128;
  localparam int unsigned IW   = $clog2(SIZE);

  logic          i_clock;
  logic          i_reset;
  logic          i_rd;
  logic [AW-1:0] i_addr;
  logic          i_flush;
  logic [DW-1:0] o_data;
  logic          o_ready;
  logic          o_busy;
  logic [AW-1:0] o_set_addr;
  logic          o_set_wr;
  logic          o_set_cl;
  logic [DW-1:0] o_set_data;
  logic [DW-1:0] i_set_data;
  logic          i_set_hit;
  logic          o_mem_rd;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] i_mem_data;
  logic          i_mem_ack;

  int n_vec;
  int n_err;

  icache_controller #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .SIZE       (SIZE)
  ) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_rd       (i_rd),
    .i_addr     (i_addr),
    .i_flush    (i_flush),
    .o_data     (o_data),
    .o_ready    (o_ready),
    .o_busy     (o_busy),
    .o_set_addr (o_set_addr),
    .o_set_wr   (o_set_wr),
    .o_set_cl   (o_set_cl),
    .o_set_data (o_set_data),
    .i_set_data (i_set_data),
    .i_set_hit  (i_set_hit),
    .o_mem_rd   (o_mem_rd),
    .o_mem_addr (o_mem_addr),
    .i_mem_data (i_mem_data),
    .i_mem_ack  (i_mem_ack)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Cache-set environment; starts with every entry valid so a missed sweep shows up.
  logic          set_vld [SIZE];
  logic [DW-1:0] set_mem [SIZE];
  logic          poison;
  logic [IW-1:0] set_idx;

  assign set_idx = o_set_addr[IW-1:0];

  always_comb begin
    i_set_hit  = 1'b0;
    i_set_data = '0;
    if (!o_set_wr && !o_set_cl && o_set_addr < AW'(SIZE)) begin
      i_set_hit  = set_vld[set_idx];
      i_set_data = set_mem[set_idx];
    end
  end

  always @(posedge i_clock) begin
    if (poison) begin
      for (int i = 0; i < SIZE; i++) begin
        set_vld[i] <= 1'b1;
        set_mem[i] <= 32'hBAD0_0000 | i;
      end
    end else if (o_set_wr) begin
      set_vld[set_idx] <= 1'b1;
      set_mem[set_idx] <= o_set_data;
    end else if (o_set_cl) begin
      set_vld[set_idx] <= 1'b0;
    end
  end

  // Reference: what the cache should hold after the transactions issued so far.
  bit            ref_vld  [SIZE];
  logic [DW-1:0] ref_data [SIZE];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < SIZE; i++) ref_vld[i] = 1'b0;
  endtask

  // Entered in the low phase of the first sweep cycle; returns in the first idle cycle.
  task automatic check_sweep(input int restart_at);
    int exp_idx = 0;
    int cyc     = 0;
    while (exp_idx < SIZE) begin
      #1;
      check_eq("sweep_busy", 64'(o_busy), 64'd1);
      check_eq("sweep_cl", 64'(o_set_cl), 64'd1);
      check_eq("sweep_addr", 64'(o_set_addr), 64'(exp_idx));
      check_eq("sweep_ready", 64'(o_ready), 64'd0);
      check_eq("sweep_wr", 64'(o_set_wr), 64'd0);
      check_eq("sweep_mem_rd", 64'(o_mem_rd), 64'd0);
      if (cyc == restart_at) begin
        i_flush = 1'b1;
        exp_idx = 0;
      end else begin
        exp_idx++;
      end
      cyc++;
      @(negedge i_clock);
      i_flush = 1'b0;
    end
    #1;
    check_eq("sweep_done_busy", 64'(o_busy), 64'd0);
    check_eq("sweep_done_cl", 64'(o_set_cl), 64'd0);
    ref_clear();
  endtask

  // flush_at: -1 none, 0..w pulses flush in that MEM_REQ cycle, w+1 in the FILL cycle.
  task automatic do_read(input int unsigned a, input int w, input logic [DW-1:0] d,
                         input int flush_at);
    i_rd   = 1'b1;
    i_addr = AW'(a);
    #1;
    check_eq("hit_vs_model", 64'(i_set_hit), 64'(ref_vld[a]));
    check_eq("idle_set_addr", 64'(o_set_addr), 64'(a));
    if (ref_vld[a]) begin
      check_eq("hit_ready", 64'(o_ready), 64'd1);
      check_eq("hit_data", 64'(o_data), 64'(ref_data[a]));
      check_eq("hit_no_mem_rd", 64'(o_mem_rd), 64'd0);
      @(negedge i_clock);
      i_rd = 1'b0;
      return;
    end
    check_eq("miss_ready0", 64'(o_ready), 64'd0);
    check_eq("miss_mem_rd0", 64'(o_mem_rd), 64'd0);
    for (int k = 0; k <= w; k++) begin
      @(negedge i_clock);
      i_mem_ack  = (k == w);
      i_mem_data = (k == w) ? d : DW'($urandom);
      i_flush    = (k == flush_at);
      #1;
      check_eq("memreq_rd", 64'(o_mem_rd), 64'd1);
      check_eq("memreq_addr", 64'(o_mem_addr), 64'(a));
      check_eq("memreq_ready", 64'(o_ready), 64'd0);
      check_eq("memreq_wr", 64'(o_set_wr), 64'd0);
    end
    @(negedge i_clock);
    i_mem_ack  = 1'b0;
    i_mem_data = DW'($urandom);
    i_flush    = (flush_at == w + 1);
    #1;
    check_eq("fill_ready", 64'(o_ready), 64'd1);
    check_eq("fill_data", 64'(o_data), 64'(d));
    check_eq("fill_wr", 64'(o_set_wr), 64'd1);
    check_eq("fill_set_addr", 64'(o_set_addr), 64'(a));
    check_eq("fill_set_data", 64'(o_set_data), 64'(d));
    check_eq("fill_cl", 64'(o_set_cl), 64'd0);
    check_eq("fill_mem_rd", 64'(o_mem_rd), 64'd0);
    ref_vld[a]  = 1'b1;
    ref_data[a] = d;
    @(negedge i_clock);
    i_flush = 1'b0;
    i_rd    = 1'b0;
    if (flush_at >= 0) begin
      // Hold a request through the sweep: it must not be served.
      i_rd   = 1'b1;
      i_addr = AW'(a);
      check_sweep(-1);
      i_rd = 1'b0;
    end
  endtask

  task automatic do_flush(input int restart_at);
    i_flush = 1'b1;
    i_rd    = 1'b1;
    i_addr  = AW'($urandom_range(0, 15));
    #1;
    check_eq("flush_prio_ready", 64'(o_ready), 64'd0);
    check_eq("flush_idle_busy", 64'(o_busy), 64'd0);
    @(negedge i_clock);
    i_flush = 1'b0;
    i_rd    = 1'b0;
    check_sweep(restart_at);
  endtask

  task automatic do_reset_midmiss(input int unsigned a);
    i_rd   = 1'b1;
    i_addr = AW'(a);
    @(negedge i_clock);
    i_mem_ack = 1'b0;
    #1;
    check_eq("pre_reset_mem_rd", 64'(o_mem_rd), 64'd1);
    #2;
    i_reset = 1'b0;
    #1;
    check_eq("reset_mem_rd_async", 64'(o_mem_rd), 64'd0);
    check_eq("reset_busy", 64'(o_busy), 64'd1);
    check_eq("reset_cl", 64'(o_set_cl), 64'd1);
    check_eq("reset_set_addr", 64'(o_set_addr), 64'd0);
    check_eq("reset_ready", 64'(o_ready), 64'd0);
    i_rd = 1'b0;
    @(negedge i_clock);
    i_reset = 1'b1;
    check_sweep(-1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: run exceeded time budget");
    $fatal(1);
  end

  initial begin
    int unsigned a;
    int          w;
    int          fa;
    int          r;
    int          cnt;
    n_vec      = 0;
    n_err      = 0;
    i_reset    = 1'b0;
    i_rd       = 1'b0;
    i_addr     = '0;
    i_flush    = 1'b0;
    i_mem_data = '0;
    i_mem_ack  = 1'b0;
    poison     = 1'b1;
    for (int i = 0; i < SIZE; i++) begin
      ref_vld[i]  = 1'b0;
      ref_data[i] = '0;
    end

    repeat (2) @(negedge i_clock);
    poison = 1'b0;
    #1;
    check_eq("rst_ready", 64'(o_ready), 64'd0);
    check_eq("rst_set_wr", 64'(o_set_wr), 64'd0);
    check_eq("rst_mem_rd", 64'(o_mem_rd), 64'd0);
    check_eq("rst_busy", 64'(o_busy), 64'd1);
    check_eq("rst_set_cl", 64'(o_set_cl), 64'd1);
    repeat (2) @(negedge i_clock);
    i_reset = 1'b1;
    check_sweep(-1);
    cnt = 0;
    for (int i = 0; i < SIZE; i++) cnt += int'(set_vld[i]);
    check_eq("init_all_invalid", 64'(cnt), 64'd0);

    // Directed scenarios.
    do_read(32'h40, 3, 32'hDEAD_BEEF, -1);
    do_read(32'h40, 0, 32'h0, -1);
    do_read(32'h7F, 0, 32'h1234_5678, -1);
    do_read(32'h10, 2, 32'hCAFE_0010, 1);
    do_read(32'h10, 0, 32'hCAFE_0011, -1);
    do_read(32'h11, 1, 32'hCAFE_0012, 2);
    do_read(32'h20, 1, 32'h2020_2020, -1);
    do_flush(50);
    do_reset_midmiss(32'h33);

    // Randomized mix of hits, misses, flushes and resets.
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, SIZE - 1);
      else a = $urandom_range(0, 15);
      if (r < 80) begin
        w  = int'($urandom_range(0, 4));
        fa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, w + 1)) : -1;
        do_read(a, w, DW'($urandom), fa);
      end else if (r < 92) begin
        do_flush(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, SIZE - 1)) : -1);
      end else if (!ref_vld[a]) begin
        do_reset_midmiss(a);
      end else begin
        do_read(a, 0, DW'($urandom), -1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
